// File: rtl/reg_scoreboard_pkg.sv
// y86_reg_pkg: register-ID types and constants shared by the scoreboard files.
package y86_reg_pkg;
  typedef logic [3:0] reg_id_t;
  localparam reg_id_t REG_NONE = 4'hF;
  localparam reg_id_t REG_RSP = 4'h4;
  localparam int NUM_ARCH_REGS = 15;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode issue and write-back retire channels of the scoreboard.
interface reg_scoreboard_if;
  import y86_reg_pkg::*;
  logic issue_valid;
  logic issue_ready;
  reg_id_t issue_srcA;
  reg_id_t issue_srcB;
  reg_id_t issue_dstE;
  reg_id_t issue_dstM;
  logic retire_e_valid;
  reg_id_t retire_e_reg;
  logic retire_m_valid;
  reg_id_t retire_m_reg;
  modport master (
    output issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM,
    output retire_e_valid, retire_e_reg, retire_m_valid, retire_m_reg,
    input issue_ready
  );
  modport slave (
    input issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM,
    input retire_e_valid, retire_e_reg, retire_m_valid, retire_m_reg,
    output issue_ready
  );
endinterface

// File: rtl/reg_scoreboard_pending_counter.sv
// reg_pending_counter: outstanding-write counter for one register with clamp-on-underflow.
module reg_pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             fire,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             underflow,
  output logic             fits
);
  localparam int SW = CNT_W + 2;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0] sum;
  // Headroom uses the requested increment so ready never depends on valid.
  assign fits = SW'(count_q) + SW'(inc) <= SW'({CNT_W{1'b1}});
  assign sum = SW'(count_q) + (fire ? SW'(inc) : '0);
  assign underflow = !flush && sum < SW'(dec);
  assign count_d = flush || underflow ? '0 : CNT_W'(sum - SW'(dec));
  assign count = count_q;
  assign nonzero = |count_q;
  always_ff @(posedge clock)
    count_q <= reset ? '0 : count_d;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker gating decode issue on RAW/overflow hazards.
module reg_scoreboard
  import y86_reg_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int CNT_W = 2,
  parameter int STALL_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  reg_scoreboard_if.slave     sb,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                busy,
  output logic                underflow_err,
  output logic [STALL_W-1:0]  stall_count
);
  logic [CNT_W-1:0] cnt [16];
  logic [NUM_REGS-1:0] nz, uf, fits;
  logic fire, underflow_err_q, underflow_err_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  assign fire = sb.issue_valid && sb.issue_ready;
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic [1:0] inc, dec;
    assign inc = 2'(sb.issue_dstE == reg_id_t'(r)) + 2'(sb.issue_dstM == reg_id_t'(r));
    assign dec = 2'(sb.retire_e_valid && sb.retire_e_reg == reg_id_t'(r))
               + 2'(sb.retire_m_valid && sb.retire_m_reg == reg_id_t'(r));
    reg_pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock, .reset, .flush, .fire, .inc, .dec,
      .count(cnt[r]), .nonzero(nz[r]), .underflow(uf[r]), .fits(fits[r])
    );
  end
  // IDs without a counter (including REG_NONE) read as always free.
  for (genvar r = NUM_REGS; r < 16; r++) begin : g_pad
    assign cnt[r] = '0;
  end
  assign sb.issue_ready = cnt[sb.issue_srcA] == '0 && cnt[sb.issue_srcB] == '0 && &fits;
  assign pending_mask = nz;
  assign busy = |nz;
  assign underflow_err = underflow_err_q;
  assign stall_count = stall_q;
  always_comb begin
    underflow_err_d = underflow_err_q | (|uf);
    stall_d = sb.issue_valid && !sb.issue_ready && !(&stall_q) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clock) begin
    underflow_err_q <= reset ? 1'b0 : underflow_err_d;
    stall_q <= reset ? '0 : stall_d;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Hazard scheduler guarding the two-read/two-write register file of the pipelined Y86-64 core. Tracks outstanding writes per architectural register (IDs 0x0-0xE; 0xF = none) and grants issue only when both source registers have no pending write. Retirements arrive from the same E/M write-back ports that drive the register file. Sits between decode (issue side) and write-back (retire side).

Parameters:
NUM_REGS, 15, architectural registers tracked (IDs 0..NUM_REGS-1).
CNT_W, 2, width of each per-register pending-write counter (max 2^CNT_W-1 outstanding).
STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
clock  input  1  system clock, all state on posedge.
reset  input  1  synchronous, active-high.
flush  input  1  pipeline flush; clears all pending counters.
issue_valid  input  1  decode presents an instruction.
issue_ready  output  1  combinational grant; issue fires when issue_valid && issue_ready.
issue_srcA  input  4  source register A (0xF = none).
issue_srcB  input  4  source register B (0xF = none).
issue_dstE  input  4  E-port destination (0xF = none).
issue_dstM  input  4  M-port destination (0xF = none).
retire_e_valid  input  1  E-port write-back this cycle.
retire_e_reg  input  4  E-port destination being written.
retire_m_valid  input  1  M-port write-back this cycle.
retire_m_reg  input  4  M-port destination being written.
pending_mask  output  NUM_REGS  bit r = counter r nonzero (registered).
busy  output  1  OR of pending_mask.
underflow_err  output  1  sticky: retire seen on a zero counter.
stall_count  output  STALL_W  saturating count of stalled cycles.

Behaviour:
- Reset: all counters 0, pending_mask 0, busy 0, underflow_err 0, stall_count 0.
- Reset has priority over flush; flush over issue/retire.
- issue_ready = srcA free AND srcB free AND no destination overflow; computed from current registered counters only (no same-cycle retire bypass).
- Source free: ID == 0xF, or counter == 0.
- Overflow check: increment per register = (dstE==r) + (dstM==r), ignoring 0xF; ready requires counter + increment <= 2^CNT_W-1. dstE == dstM (e.g. popq %rsp) increments that counter by 2.
- Issue fire: counters of dstE/dstM incremented next cycle. issue_ready is independent of issue_valid.
- Retire: counter of retire_e_reg and/or retire_m_reg decremented by 1 each; same reg on both ports: -2. Retire with reg 0xF ignored.
- Simultaneous issue and retire on same register: net = inc - dec, applied in one cycle.
- Underflow (decrement exceeds counter): counter clamps to 0, underflow_err set, held until reset.
- flush: all counters to 0 next cycle; issue/retire that cycle ignored; underflow_err and stall_count preserved.
- stall_count: +1 each cycle with issue_valid && !issue_ready, saturates at all-ones; not cleared by flush.
- pending_mask/busy derived from registered counters: reflect a fire/retire one cycle later.
- Latency: issue at cycle N blocks a dependent reader from cycle N+1; retire at cycle N frees a reader at N+1.

Decomposition:
- Package y86_reg_pkg: reg_id_t (4-bit), REG_NONE = 4'hF, REG_RSP = 4'h4, NUM_ARCH_REGS = 15.
- Sub-module reg_pending_counter: one instance per register; inputs inc (0..2), dec (0..2), flush; outputs count, nonzero, underflow pulse, headroom check.

Test Plan:
- Reset then issue srcA=F,srcB=F,dstE=3 -> ready=1; next cycle pending_mask=0x0008, busy=1.
- With reg 3 pending, issue srcA=3 -> ready=0 for 4 cycles, stall_count=4; retire_e reg 3 -> ready=1 following cycle, mask=0.
- Issue dstE=4,dstM=4 (popq %rsp) -> counter[4]=2; single retire_e 4 -> still pending; retire_m 4 -> cleared.
- Issue dstE=2 three times (CNT_W=2) -> counter 3; fourth issue to dst 2 -> ready=0; same-cycle retire of 2 does not raise ready until next cycle.
- Retire_m reg 7 with counter 0 -> underflow_err=1, counter stays 0; flush -> mask=0, err still 1; reset -> err=0.
- Issue firing with retire on same reg 5 (counter 1) -> counter stays 1, mask bit 5 stays set.
